// File: rtl/pacman_game_ctrl_if.sv
// Button inputs and display-side outputs of the PacMan game sequencer.
interface pacman_game_ctrl_if;
  logic       btn_l;
  logic       btn_r;
  logic [2:0] pos;
  logic [2:0] idx;
  logic       eaten;
  logic       direction;
  logic [3:0] anodes;
  logic       level_done;

  modport master (
    output btn_l, btn_r,
    input  pos, idx, eaten, direction, anodes, level_done
  );

  modport slave (
    input  btn_l, btn_r,
    output pos, idx, eaten, direction, anodes, level_done
  );
endinterface

// File: rtl/pacman_game_ctrl.sv
// PacMan game sequencer: position/direction/eaten-mask FSM plus digit scan mux.
// Build option PACMAN_WRAP_EN: moves past either end wrap around instead of holding.
module pacman_game_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int STEP_DIV   = 50000000,
  parameter int SCAN_DIV   = 100000,
  parameter int WIN_TICKS  = 3
) (
  input  logic               clk,
  input  logic               rst,
  pacman_game_ctrl_if.slave  io
);

  localparam int STEP_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int WIN_W  = $clog2(WIN_TICKS + 1);
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WIN} state_t;

  state_t              state_q, state_d;
  logic [2:0]          pos_q, pos_d;
  logic                dir_q, dir_d;
  logic [3:0]          eaten_mask_q, eaten_mask_d;
  logic [2:0]          idx_q, idx_d;
  logic [3:0]          anodes_q, anodes_d;
  logic                eaten_q, eaten_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic                btn_l_q, btn_r_q;

  logic       rise_l, rise_r, tick, dir_upd, at_edge, move;
  logic [2:0] nxt;

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    eaten_mask_d = eaten_mask_q;
    idx_d        = idx_q;
    scan_cnt_d   = scan_cnt_q;
    step_cnt_d   = step_cnt_q;
    win_cnt_d    = win_cnt_q;
    nxt          = pos_q;
    move         = 1'b0;
    at_edge      = 1'b0;

    rise_l = io.btn_l & ~btn_l_q;
    rise_r = io.btn_r & ~btn_r_q;
    // Simultaneous rises cancel for direction but still count as a press.
    dir_upd = dir_q;
    if (rise_l && !rise_r) dir_upd = 1'b1;
    if (rise_r && !rise_l) dir_upd = 1'b0;

    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == LAST) ? 3'd0 : idx_q + 3'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    end

    tick = (state_q != S_IDLE) && (step_cnt_q == STEP_W'(STEP_DIV - 1));
    if (state_q == S_IDLE || tick) step_cnt_d = '0;
    else                           step_cnt_d = step_cnt_q + STEP_W'(1);

    case (state_q)
      S_IDLE: begin
        if (rise_l || rise_r) begin
          state_d = S_RUN;
          dir_d   = dir_upd;
        end
      end
      S_RUN: begin
        dir_d = dir_upd;
        if (eaten_mask_q == 4'b1111) begin
          state_d = S_WIN;
        end else if (tick) begin
          at_edge = dir_d ? (pos_q == 3'd0) : (pos_q == LAST);
          if (at_edge) begin
`ifdef PACMAN_WRAP_EN
            nxt  = dir_d ? LAST : 3'd0;
            move = 1'b1;
`else
            move = 1'b0;
`endif
          end else begin
            nxt  = dir_d ? pos_q - 3'd1 : pos_q + 3'd1;
            move = 1'b1;
          end
          if (move) begin
            pos_d                  = nxt;
            eaten_mask_d[nxt[1:0]] = 1'b1;
          end
        end
      end
      S_WIN: begin
        if (tick) begin
          if (win_cnt_q == WIN_W'(WIN_TICKS - 1)) begin
            state_d      = S_IDLE;
            win_cnt_d    = '0;
            eaten_mask_d = 4'b0001 << pos_q[1:0];
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Tracking the next mask every cycle keeps eaten=1 wherever PacMan sits.
    anodes_d = ~(4'b0001 << idx_d[1:0]);
    eaten_d  = eaten_mask_d[idx_d[1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pos_q        <= 3'd0;
      dir_q        <= 1'b0;
      eaten_mask_q <= 4'b0001;
      idx_q        <= 3'd0;
      anodes_q     <= 4'b1110;
      eaten_q      <= 1'b1;
      scan_cnt_q   <= '0;
      step_cnt_q   <= '0;
      win_cnt_q    <= '0;
      btn_l_q      <= 1'b0;
      btn_r_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      eaten_mask_q <= eaten_mask_d;
      idx_q        <= idx_d;
      anodes_q     <= anodes_d;
      eaten_q      <= eaten_d;
      scan_cnt_q   <= scan_cnt_d;
      step_cnt_q   <= step_cnt_d;
      win_cnt_q    <= win_cnt_d;
      btn_l_q      <= io.btn_l;
      btn_r_q      <= io.btn_r;
    end
  end

  assign io.pos        = pos_q;
  assign io.idx        = idx_q;
  assign io.eaten      = eaten_q;
  assign io.direction  = dir_q;
  assign io.anodes     = anodes_q;
  assign io.level_done = (state_q == S_WIN);

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Directed bench for pacman_game_ctrl with STEP_DIV=4, SCAN_DIV=2, WIN_TICKS=2.
module tb_pacman_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   scan_cyc;

  pacman_game_ctrl_if io();

  pacman_game_ctrl #(
    .NUM_DIGITS(4), .STEP_DIV(4), .SCAN_DIV(2), .WIN_TICKS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  // Free-running scan reference: idx advances every SCAN_DIV=2 clocks.
  always @(posedge clk or posedge rst) begin
    if (rst) scan_cyc <= 0;
    else     scan_cyc <= scan_cyc + 1;
  end

  typedef struct {
    string      tag;
    logic [2:0] pos;
    logic       dir;
    logic       ld;
    logic [3:0] mask;
  } exp_t;

  exp_t sb[$];

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] p, input logic d,
                      input logic l, input logic [3:0] m);
    exp_t e;
    e.tag = tag; e.pos = p; e.dir = d; e.ld = l; e.mask = m;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t       e;
    int         xi;
    logic [3:0] xa;
    logic [3:0] m;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      xi = (scan_cyc / 2) % 4;
      xa = ~(4'b0001 << xi);
      m  = e.mask;
      cmp({e.tag, ".pos"},        32'(io.pos),        32'(e.pos));
      cmp({e.tag, ".direction"},  32'(io.direction),  32'(e.dir));
      cmp({e.tag, ".level_done"}, 32'(io.level_done), 32'(e.ld));
      cmp({e.tag, ".mask"},       32'(dut.eaten_mask_q), 32'(e.mask));
      cmp({e.tag, ".idx"},        32'(io.idx),        32'(xi));
      cmp({e.tag, ".anodes"},     32'(io.anodes),     32'(xa));
      cmp({e.tag, ".eaten"},      32'(io.eaten),      32'(m[xi]));
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    io.btn_l = 1'b0;
    io.btn_r = 1'b0;
    clk_n(2);
    push("reset", 3'd0, 1'b0, 1'b0, 4'b0001); check_sb();
    rst = 1'b0;

    // Idle scan: idx 1,2,3,0 every two clocks, PacMan parked at 0.
    for (int k = 0; k < 4; k++) begin
      clk_n(2);
      push($sformatf("scan%0d", k), 3'd0, 1'b0, 1'b0, 4'b0001); check_sb();
    end

    // Right press starts the level; ticks every 4 clocks eat every digit.
    io.btn_r = 1'b1; clk_n(1); io.btn_r = 1'b0;
    push("start", 3'd0, 1'b0, 1'b0, 4'b0001); check_sb();
    clk_n(3); push("pre_tick", 3'd0, 1'b0, 1'b0, 4'b0001); check_sb();
    clk_n(1); push("step1", 3'd1, 1'b0, 1'b0, 4'b0011); check_sb();
    clk_n(4); push("step2", 3'd2, 1'b0, 1'b0, 4'b0111); check_sb();
    clk_n(4); push("step3", 3'd3, 1'b0, 1'b0, 4'b1111); check_sb();
    clk_n(1); push("win", 3'd3, 1'b0, 1'b1, 4'b1111); check_sb();

    // Buttons are ignored in WIN.
    io.btn_l = 1'b1; clk_n(1); io.btn_l = 1'b0;
    push("win_btn", 3'd3, 1'b0, 1'b1, 4'b1111); check_sb();
    clk_n(5); push("win_hold", 3'd3, 1'b0, 1'b1, 4'b1111); check_sb();
    clk_n(1); push("restart", 3'd3, 1'b0, 1'b0, 4'b1000); check_sb();

    // Right edge at pos 3.
    io.btn_r = 1'b1; clk_n(1); io.btn_r = 1'b0;
    push("run2", 3'd3, 1'b0, 1'b0, 4'b1000); check_sb();
    clk_n(4);
`ifdef PACMAN_WRAP_EN
    push("right_edge", 3'd0, 1'b0, 1'b0, 4'b1001); check_sb();
`else
    push("right_edge", 3'd3, 1'b0, 1'b0, 4'b1000); check_sb();
`endif

    // Asynchronous reset between clock edges.
    #3 rst = 1'b1;
    #1 push("async_rst", 3'd0, 1'b0, 1'b0, 4'b0001); check_sb();
    @(negedge clk); rst = 1'b0;
    clk_n(1);

    io.btn_r = 1'b1; clk_n(1); io.btn_r = 1'b0;
    clk_n(1);
    io.btn_l = 1'b1; io.btn_r = 1'b1; clk_n(1); io.btn_l = 1'b0; io.btn_r = 1'b0;
    push("both_btn", 3'd0, 1'b0, 1'b0, 4'b0001); check_sb();
    clk_n(2); push("r_step1", 3'd1, 1'b0, 1'b0, 4'b0011); check_sb();
    clk_n(4); push("r_step2", 3'd2, 1'b0, 1'b0, 4'b0111); check_sb();

    // Left press coincides with a tick: the move uses the new direction.
    clk_n(3); io.btn_l = 1'b1; clk_n(1); io.btn_l = 1'b0;
    push("turn_tick", 3'd1, 1'b1, 1'b0, 4'b0111); check_sb();
    clk_n(4); push("left1", 3'd0, 1'b1, 1'b0, 4'b0111); check_sb();
    clk_n(4);
`ifdef PACMAN_WRAP_EN
    push("left_edge", 3'd3, 1'b1, 1'b0, 4'b1111); check_sb();
    clk_n(1); push("left_win", 3'd3, 1'b1, 1'b1, 4'b1111); check_sb();
`else
    push("left_edge", 3'd0, 1'b1, 1'b0, 4'b0111); check_sb();
    clk_n(1); push("left_hold", 3'd0, 1'b1, 1'b0, 4'b0111); check_sb();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
